// File: rtl/planar_pixel_fifo_if.sv
// rtl/planar_pixel_fifo_if.sv - plane-word input / packed-pixel output bundle of the planar pixel FIFO
interface planar_pixel_fifo_if #(
    parameter int CH_BITS      = 4,
    parameter int PIX_PER_WORD = 8,
    parameter int LOG2DEPTH    = 6
);
    localparam int WORD_W = CH_BITS * PIX_PER_WORD;
    localparam int PIX_W  = 3 * CH_BITS;

    logic              flush;
    logic [WORD_W-1:0] r_data;
    logic [WORD_W-1:0] g_data;
    logic [WORD_W-1:0] b_data;
    logic              r_rts;
    logic              g_rts;
    logic              b_rts;
    logic              in_rtr;
    logic [PIX_W-1:0]  out_pixel;
    logic              out_rts;
    logic              out_rtr;
    logic [LOG2DEPTH:0] level;
    logic              underrun;
    logic              underrun_clr;

    // Producer / consumer side (plane fetchers, VGA stage, control)
    modport master (
        output flush, r_data, g_data, b_data, r_rts, g_rts, b_rts,
        output out_rtr, underrun_clr,
        input  in_rtr, out_pixel, out_rts, level, underrun
    );

    // FIFO side
    modport slave (
        input  flush, r_data, g_data, b_data, r_rts, g_rts, b_rts,
        input  out_rtr, underrun_clr,
        output in_rtr, out_pixel, out_rts, level, underrun
    );
endinterface

// File: rtl/planar_pixel_fifo.sv
// rtl/planar_pixel_fifo.sv - planar R/G/B word to packed RGB pixel FIFO with level, flush and underrun
module planar_pixel_fifo #(
    parameter int                     CH_BITS      = 4,
    parameter int                     PIX_PER_WORD = 8,
    parameter int                     DEPTH        = 64,
    parameter int                     LOG2DEPTH    = 6,
    parameter logic [3*CH_BITS-1:0]   FILL_PIXEL   = '0
) (
    input logic               clk,
    input logic               rst_,
    planar_pixel_fifo_if.slave bus
);
    localparam int PIX_W = 3 * CH_BITS;
    localparam int LVL_W = LOG2DEPTH + 1;
    localparam logic [LVL_W-1:0]     DEPTH_L  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0]     PPW_L    = LVL_W'(PIX_PER_WORD);
    localparam logic [LVL_W-1:0]     ONE_L    = LVL_W'(1);
    localparam logic [LOG2DEPTH-1:0] PTR_STEP = LOG2DEPTH'(PIX_PER_WORD);
    localparam logic [LOG2DEPTH-1:0] PTR_ONE  = LOG2DEPTH'(1);

    logic [PIX_W-1:0]     mem [DEPTH];
    logic [LOG2DEPTH-1:0] rd_ptr;
    logic [LOG2DEPTH-1:0] wr_ptr;
    logic [LVL_W-1:0]     level_q;
    logic [LVL_W-1:0]     level_nxt;
    logic                 underrun_q;
    logic                 in_xfc;
    logic                 out_xfc;
    logic                 out_rts_w;

    // A beat is taken only when a whole word fits against the current level;
    // a pop in the same cycle does not open room for it.
    assign in_xfc    = bus.r_rts & bus.g_rts & bus.b_rts & ~bus.flush
                     & ((DEPTH_L - level_q) >= PPW_L);
    assign out_rts_w = (level_q != '0) & ~bus.flush;
    assign out_xfc   = out_rts_w & bus.out_rtr;

    assign bus.in_rtr    = in_xfc;
    assign bus.out_rts   = out_rts_w;
    assign bus.out_pixel = out_rts_w ? mem[rd_ptr] : FILL_PIXEL;
    assign bus.level     = level_q;
    assign bus.underrun  = underrun_q;

    // Next occupancy: a word in and a pixel out may coincide
    always_comb begin
        level_nxt = level_q;
        if (in_xfc)  level_nxt = level_nxt + PPW_L;
        if (out_xfc) level_nxt = level_nxt - ONE_L;
    end

    // Unpack a beat into PIX_PER_WORD entries; the address wraps so a word may straddle the end
    always_ff @(posedge clk) begin
        if (rst_ && in_xfc) begin
            for (int k = 0; k < PIX_PER_WORD; k++) begin
                mem[wr_ptr + LOG2DEPTH'(k)] <= {bus.r_data[k*CH_BITS +: CH_BITS],
                                                bus.g_data[k*CH_BITS +: CH_BITS],
                                                bus.b_data[k*CH_BITS +: CH_BITS]};
            end
        end
    end

    // Pointers and occupancy; flush empties the FIFO at frame start
    always_ff @(posedge clk) begin
        if (!rst_) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            level_q <= '0;
        end else if (bus.flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (in_xfc)  wr_ptr <= wr_ptr + PTR_STEP;
            if (out_xfc) rd_ptr <= rd_ptr + PTR_ONE;
            level_q <= level_nxt;
        end
    end

    // Sticky starvation flag; a new underrun beats a simultaneous clear, flush leaves it alone
    always_ff @(posedge clk) begin
        if (!rst_) begin
            underrun_q <= 1'b0;
        end else if (bus.out_rtr && (level_q == '0) && !bus.flush) begin
            underrun_q <= 1'b1;
        end else if (bus.underrun_clr) begin
            underrun_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_planar_pixel_fifo.sv
// tb/tb_planar_pixel_fifo.sv - scoreboard bench for planar_pixel_fifo, default and 5-bit/4-pixel/16-deep builds
module tb_planar_pixel_fifo;
    logic clk;
    logic rst_;

    planar_pixel_fifo_if #(.CH_BITS(4), .PIX_PER_WORD(8), .LOG2DEPTH(6)) ifa ();
    planar_pixel_fifo_if #(.CH_BITS(5), .PIX_PER_WORD(4), .LOG2DEPTH(4)) ifb ();

    planar_pixel_fifo #(.CH_BITS(4), .PIX_PER_WORD(8), .DEPTH(64), .LOG2DEPTH(6), .FILL_PIXEL(12'h000))
        dut_a (.clk(clk), .rst_(rst_), .bus(ifa));
    planar_pixel_fifo #(.CH_BITS(5), .PIX_PER_WORD(4), .DEPTH(16), .LOG2DEPTH(4), .FILL_PIXEL(15'h000))
        dut_b (.clk(clk), .rst_(rst_), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    int          la, lb;
    logic        ua, ub;
    logic [31:0] qa [$];
    logic [31:0] qb [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pix(input logic [31:0] r, input logic [31:0] g,
                                        input logic [31:0] b, input int k, input int ch);
        logic [31:0] m;
        m = (32'h1 << ch) - 32'h1;
        return (((r >> (k*ch)) & m) << (2*ch)) | (((g >> (k*ch)) & m) << ch) | ((b >> (k*ch)) & m);
    endfunction

    task automatic rts_a(input logic v);
        ifa.r_rts = v; ifa.g_rts = v; ifa.b_rts = v;
    endtask

    task automatic rts_b(input logic v);
        ifb.r_rts = v; ifb.g_rts = v; ifb.b_rts = v;
    endtask

    task automatic rand_words();
        ifa.r_data = $urandom; ifa.g_data = $urandom; ifa.b_data = $urandom;
        ifb.r_data = 20'($urandom); ifb.g_data = 20'($urandom); ifb.b_data = 20'($urandom);
    endtask

    task automatic reset_all();
        rst_ = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_ = 1'b1;
        la = 0; ua = 1'b0; qa.delete();
        lb = 0; ub = 1'b0; qb.delete();
    endtask

    // One clock of instance A: check outputs against the model, then advance the model
    task automatic step_a();
        logic        ein, eout;
        logic [31:0] ep;
        @(negedge clk);
        ein  = ifa.r_rts & ifa.g_rts & ifa.b_rts & ~ifa.flush & ((64 - la) >= 8);
        eout = (la != 0) && !ifa.flush;
        ep   = (eout && qa.size() > 0) ? qa[0] : 32'h000;
        chk("a_in_rtr", {31'b0, ifa.in_rtr}, {31'b0, ein});
        chk("a_out_rts", {31'b0, ifa.out_rts}, {31'b0, eout});
        chk("a_out_pixel", {20'b0, ifa.out_pixel}, ep);
        chk("a_level", {25'b0, ifa.level}, la);
        chk("a_underrun", {31'b0, ifa.underrun}, {31'b0, ua});
        if (!rst_) begin
            la = 0; ua = 1'b0; qa.delete();
        end else if (ifa.flush) begin
            la = 0; qa.delete();
            if (ifa.underrun_clr) ua = 1'b0;
        end else begin
            if (ifa.out_rtr && la == 0) ua = 1'b1;
            else if (ifa.underrun_clr) ua = 1'b0;
            if (eout && ifa.out_rtr) begin
                void'(qa.pop_front());
                la--;
            end
            if (ein) begin
                for (int k = 0; k < 8; k++) qa.push_back(pix(ifa.r_data, ifa.g_data, ifa.b_data, k, 4));
                la += 8;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // One clock of instance B, same model with 5-bit channels, 4 pixels/word, depth 16
    task automatic step_b();
        logic        ein, eout;
        logic [31:0] ep;
        @(negedge clk);
        ein  = ifb.r_rts & ifb.g_rts & ifb.b_rts & ~ifb.flush & ((16 - lb) >= 4);
        eout = (lb != 0) && !ifb.flush;
        ep   = (eout && qb.size() > 0) ? qb[0] : 32'h000;
        chk("b_in_rtr", {31'b0, ifb.in_rtr}, {31'b0, ein});
        chk("b_out_rts", {31'b0, ifb.out_rts}, {31'b0, eout});
        chk("b_out_pixel", {17'b0, ifb.out_pixel}, ep);
        chk("b_level", {27'b0, ifb.level}, lb);
        chk("b_underrun", {31'b0, ifb.underrun}, {31'b0, ub});
        if (!rst_) begin
            lb = 0; ub = 1'b0; qb.delete();
        end else if (ifb.flush) begin
            lb = 0; qb.delete();
            if (ifb.underrun_clr) ub = 1'b0;
        end else begin
            if (ifb.out_rtr && lb == 0) ub = 1'b1;
            else if (ifb.underrun_clr) ub = 1'b0;
            if (eout && ifb.out_rtr) begin
                void'(qb.pop_front());
                lb--;
            end
            if (ein) begin
                for (int k = 0; k < 4; k++) qb.push_back(pix(ifb.r_data, ifb.g_data, ifb.b_data, k, 5));
                lb += 4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_ = 1'b0;
        ifa.flush = 1'b0; ifa.out_rtr = 1'b0; ifa.underrun_clr = 1'b0; rts_a(1'b0);
        ifb.flush = 1'b0; ifb.out_rtr = 1'b0; ifb.underrun_clr = 1'b0; rts_b(1'b0);
        ifa.r_data = '0; ifa.g_data = '0; ifa.b_data = '0;
        ifb.r_data = '0; ifb.g_data = '0; ifb.b_data = '0;
        reset_all();

        // Reset state
        step_a();
        chk("a_reset_level", {25'b0, ifa.level}, 32'd0);

        // One word in, then read back in pixel order
        ifa.r_data = 32'h76543210; ifa.g_data = 32'hFEDCBA98; ifa.b_data = 32'h01234567;
        rts_a(1'b1); step_a(); rts_a(1'b0);
        chk("a_t1_level", {25'b0, ifa.level}, 32'd8);
        chk("a_t1_head", {20'b0, ifa.out_pixel}, 32'h087);
        step_a();
        ifa.out_rtr = 1'b1;
        repeat (8) step_a();
        ifa.out_rtr = 1'b0;
        step_a();

        // Fill to full, then pop until a word fits again
        rts_a(1'b1);
        for (int i = 0; i < 10; i++) begin
            rand_words();
            step_a();
        end
        chk("a_full_level", {25'b0, ifa.level}, 32'd64);
        chk("a_full_in_rtr", {31'b0, ifa.in_rtr}, 32'd0);
        ifa.out_rtr = 1'b1;
        repeat (7) step_a();
        chk("a_57_level", {25'b0, ifa.level}, 32'd57);
        chk("a_57_in_rtr", {31'b0, ifa.in_rtr}, 32'd0);
        step_a();
        chk("a_56_in_rtr", {31'b0, ifa.in_rtr}, 32'd1);
        rand_words();
        step_a();
        chk("a_63_level", {25'b0, ifa.level}, 32'd63);

        // Mixed traffic across many pointer wraps
        for (int i = 0; i < 300; i++) begin
            rand_words();
            rts_a($urandom_range(0, 3) != 0);
            ifa.out_rtr = ($urandom_range(0, 2) != 0);
            step_a();
        end
        rts_a(1'b0);
        ifa.out_rtr = 1'b1;
        for (int i = 0; i < 100 && la > 0; i++) step_a();
        chk("a_drained", {25'b0, ifa.level}, 32'd0);

        // Underrun: set, sticky, cleared, set-wins
        repeat (3) step_a();
        chk("a_underrun_set", {31'b0, ifa.underrun}, 32'd1);
        chk("a_fill_pixel", {20'b0, ifa.out_pixel}, 32'h000);
        ifa.out_rtr = 1'b0; ifa.underrun_clr = 1'b1; step_a();
        ifa.underrun_clr = 1'b0; step_a();
        chk("a_underrun_clr", {31'b0, ifa.underrun}, 32'd0);
        ifa.out_rtr = 1'b1; ifa.underrun_clr = 1'b1; step_a();
        chk("a_underrun_setwins", {31'b0, ifa.underrun}, 32'd1);
        ifa.out_rtr = 1'b0; step_a();
        ifa.underrun_clr = 1'b0;

        // Flush at level 40 with everything asserted
        rts_a(1'b1);
        repeat (5) begin rand_words(); step_a(); end
        chk("a_40_level", {25'b0, ifa.level}, 32'd40);
        ifa.flush = 1'b1; ifa.out_rtr = 1'b1;
        step_a();
        ifa.flush = 1'b0; ifa.out_rtr = 1'b0; rts_a(1'b0);
        step_a();
        chk("a_flush_level", {25'b0, ifa.level}, 32'd0);
        chk("a_flush_no_underrun", {31'b0, ifa.underrun}, 32'd0);
        ifa.flush = 1'b1; ifa.out_rtr = 1'b1; step_a();
        ifa.flush = 1'b0; ifa.out_rtr = 1'b0; step_a();

        // Reset in the middle of a beat
        rts_a(1'b1);
        repeat (2) begin rand_words(); step_a(); end
        rst_ = 1'b0; step_a(); rst_ = 1'b1; rts_a(1'b0);
        step_a();
        chk("a_midreset_level", {25'b0, ifa.level}, 32'd0);

        // Second build: 5-bit channels, 4 pixels per word, 16 entries
        reset_all();
        step_b();
        ifb.r_data = 20'h76543; ifb.g_data = 20'hFEDCB; ifb.b_data = 20'h01234;
        rts_b(1'b1); step_b(); rts_b(1'b0);
        chk("b_t1_level", {27'b0, ifb.level}, 32'd4);
        chk("b_t1_head", {17'b0, ifb.out_pixel}, 32'h0D74);
        ifb.out_rtr = 1'b1;
        repeat (4) step_b();
        ifb.out_rtr = 1'b0;
        rts_b(1'b1);
        for (int i = 0; i < 6; i++) begin rand_words(); step_b(); end
        chk("b_full_level", {27'b0, ifb.level}, 32'd16);
        ifb.out_rtr = 1'b1;
        repeat (3) step_b();
        chk("b_13_in_rtr", {31'b0, ifb.in_rtr}, 32'd0);
        step_b();
        rand_words();
        step_b();
        chk("b_15_level", {27'b0, ifb.level}, 32'd15);
        for (int i = 0; i < 200; i++) begin
            rand_words();
            rts_b($urandom_range(0, 3) != 0);
            ifb.out_rtr = ($urandom_range(0, 2) != 0);
            step_b();
        end
        rts_b(1'b0);
        ifb.out_rtr = 1'b1;
        for (int i = 0; i < 40 && lb > 0; i++) step_b();
        chk("b_drained", {27'b0, ifb.level}, 32'd0);
        step_b();
        chk("b_underrun_set", {31'b0, ifb.underrun}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
